mem_bus_master: RTL and testbench
=================================

# mem_bus_master

Initiator side of the CPU's shared memory bus. Takes single-beat read/write requests from the core's load/store logic and sequences en/rd/wr, a 13-bit address and the bidirectional 8-bit data bus, so that a passive RAM responder sees well-formed strobes. It owns the data-bus tristate driver on the master side and guarantees write data is stable across the rising edge of wr.

## Interface
- RD_WAIT, 1, cycles rd is held high before read data is captured (legal 1..15)
- WR_WIDTH, 1, cycles wr is held high (legal 1..15)
- RAM_BASE, 5'h00, expected addr[12:8] of the RAM window (used only with the range-check macro)

- clk  in  1  system clock, all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- req  in  1  request strobe from core, sampled only while ready=1
- we  in  1  1 = write, 0 = read; sampled with req
- req_addr  in  13  request address; sampled with req
- wdata  in  8  write data; sampled with req
- ready  out  1  master idle, can accept req
- done  out  1  one-cycle completion pulse
- rdata  out  8  read data, valid from the done cycle until the next read completes
- err  out  1  one-cycle reject pulse (range-check macro only, else tied 0)
- en  out  1  bus enable
- rd  out  1  bus read strobe
- wr  out  1  bus write strobe (responder writes on its rising edge)
- addr  out  13  bus address
- data  inout  8  bus data; driven by master only during write cycles, else high-Z

## Operation
- FSM states: IDLE, ADDR, RD_STROBE, WR_STROBE, WR_HOLD, DONE.
- IDLE: ready=1; en=rd=wr=0; data high-Z. req=1 latches we/req_addr/wdata, goes to ADDR.
- ADDR (1 cycle): en=1, addr=latched address; if write, data driven with latched wdata. Next RD_STROBE or WR_STROBE.
- RD_STROBE (RD_WAIT cycles): en=1, rd=1, data high-Z. On the edge ending the last cycle, capture data into rdata, go DONE.
- WR_STROBE (WR_WIDTH cycles): en=1, wr=1, data driven. Then WR_HOLD.
- WR_HOLD (1 cycle): en=1, wr=0, data still driven (hold time after wr rises/falls). Then DONE.
- DONE (1 cycle): done=1, bus idle (en=rd=wr=0, data high-Z), ready=0. Then IDLE.
- Master never drives data while rd=1; data driver enable = write in {ADDR, WR_STROBE, WR_HOLD}.
- Strobe counter 4 bits, loaded with RD_WAIT-1 / WR_WIDTH-1, counts down to 0.
- req while ready=0 ignored (core holds req until it sees ready).

## Timing
- Reset values: ready=1 (state IDLE), done=0, err=0, rdata=8'h00, en=rd=wr=0, addr=13'h0000, data high-Z. req ignored while rst=1.
- Read latency: accept edge E0; done high in the cycle after edge E(1+RD_WAIT). RD_WAIT=1: done 2 cycles after accept cycle.
- Write latency: done high in the cycle after edge E(2+WR_WIDTH). WR_WIDTH=1: done 3 cycles after accept cycle.
- Back-to-back: minimum one IDLE cycle between DONE and next ADDR; read throughput 1 op per 3+RD_WAIT cycles, write 1 per 4+WR_WIDTH.
- addr stays valid ADDR through WR_HOLD/RD_STROBE; returns to 0 in DONE.
- rst mid-operation: next edge forces IDLE, strobes low, data high-Z, no done. A reset during WR_STROBE leaves the already-completed responder write in place; reset during RD_STROBE leaves rdata at 0.

## Configuration
- MEM_BUS_RANGE_CHECK_EN defined: in IDLE, a req with req_addr[12:8] != RAM_BASE is rejected: err=1 for one cycle next cycle, no bus cycle, no done, ready=0 that cycle, then IDLE.
- Undefined: no check, all addresses go to the bus; err constant 0; RAM_BASE unused.

## Structure
- Package mem_bus_pkg: ADDR_W=13, DATA_W=8, state enum type, strobe-counter width constant.
- One sub-module: mem_bus_iobuf (8-bit tristate driver: oe, dout in, din out, data inout), instanced once.

## Test plan
- Write 8'h3C to 13'h0042 then read 13'h0042 (RD_WAIT=1, WR_WIDTH=1) -> rdata=8'h3C, write done 3 cycles and read done 2 cycles after accept cycle.
- Bus monitor over all tests -> data never driven by master while rd=1; data stable from ADDR through WR_HOLD on writes.
- RD_WAIT=3, WR_WIDTH=2, writes 8'hA5/8'h5A to 13'h0010/13'h0011, read back -> correct data, rd high exactly 3 cycles, wr exactly 2.
- req held continuously for 4 alternating ops -> each accepted only in IDLE, one done per op, no dropped or duplicated ops.
- rst asserted during WR_STROBE -> next cycle en=rd=wr=0, data high-Z, ready=1, no done; following read of the address returns the written value.
- With MEM_BUS_RANGE_CHECK_EN, RAM_BASE=0, req_addr=13'h1F00 -> err pulse one cycle, en never asserted, no done; req_addr=13'h00FF -> normal access.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared widths, FSM state type and request payload for the
// CPU shared-memory bus master.
package mem_bus_pkg;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BASE_W = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_RD_STROBE,
    S_WR_STROBE,
    S_WR_HOLD,
    S_DONE
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Strobe counter preload: counts down to zero over 'cycles' cycles.
  function automatic logic [CNT_W-1:0] strobe_load(input int unsigned cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/mem_bus_if.sv
// mem_bus_if: core-side request/response handshake of the memory bus master.
// master = core load/store logic, slave = mem_bus_master.
interface mem_bus_if;
  import mem_bus_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req, we, req_addr, wdata,
    input  ready, done, rdata, err
  );

  modport slave (
    input  req, we, req_addr, wdata,
    output ready, done, rdata, err
  );

endinterface

// File: rtl/mem_bus_iobuf.sv
// mem_bus_iobuf: 8-bit tristate driver for the bidirectional bus data lines.
module mem_bus_iobuf
  import mem_bus_pkg::*;
(
  input  logic              oe,
  input  logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] din,
  inout  wire  [DATA_W-1:0] data
);

  // Drive the pad only when enabled, always observe it.
  assign data = oe ? dout : {DATA_W{1'bz}};
  assign din  = data;

endmodule

// File: rtl/mem_bus_master.sv
// mem_bus_master: initiator for the shared memory bus. Sequences en/rd/wr,
// address and tristate data for single-beat reads and writes.
// Optional feature macro: MEM_BUS_RANGE_CHECK_EN (reject requests whose
// req_addr[12:8] differs from RAM_BASE with a one-cycle err pulse).
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int unsigned      RD_WAIT  = 1,
  parameter int unsigned      WR_WIDTH = 1,
  parameter logic [BASE_W-1:0] RAM_BASE = 5'h00
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_if.slave          core,
  output logic              en,
  output logic              rd,
  output logic              wr,
  output logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data
);

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic              r_oe;
  logic [DATA_W-1:0] r_dout;
  logic              r_ready;
  logic              r_done;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] w_din;
  logic              w_oe;
  req_t              w_req;

  assign w_req = '{we: core.we, addr: core.req_addr, wdata: core.wdata};
  assign w_oe  = r_oe;

  assign core.ready = r_ready;
  assign core.done  = r_done;
  assign core.rdata = r_rdata;

`ifdef MEM_BUS_RANGE_CHECK_EN
  logic r_err;
  assign core.err = r_err;
`else
  logic w_unused;
  assign core.err = 1'b0;
  assign w_unused = ^RAM_BASE;
`endif

  // Data-bus tristate driver, enabled only through the write phases.
  mem_bus_iobuf u_iobuf (
    .oe   (w_oe),
    .dout (r_dout),
    .din  (w_din),
    .data (data)
  );

  // Bus FSM; every output is registered and set for the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_oe    <= 1'b0;
      r_dout  <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_rdata <= '0;
      en      <= 1'b0;
      rd      <= 1'b0;
      wr      <= 1'b0;
      addr    <= '0;
`ifdef MEM_BUS_RANGE_CHECK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef MEM_BUS_RANGE_CHECK_EN
      r_err  <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (core.req) begin
`ifdef MEM_BUS_RANGE_CHECK_EN
            if (w_req.addr[ADDR_W-1:ADDR_W-BASE_W] != RAM_BASE) begin
              // Out-of-window request: flag it and skip the bus cycle.
              r_err   <= 1'b1;
              r_ready <= 1'b0;
              r_state <= S_DONE;
            end else
`endif
            begin
              r_we    <= w_req.we;
              r_oe    <= w_req.we;
              r_dout  <= w_req.wdata;
              r_ready <= 1'b0;
              en      <= 1'b1;
              addr    <= w_req.addr;
              r_state <= S_ADDR;
            end
          end
        end

        S_ADDR: begin
          if (r_we) begin
            wr      <= 1'b1;
            r_cnt   <= strobe_load(WR_WIDTH);
            r_state <= S_WR_STROBE;
          end else begin
            rd      <= 1'b1;
            r_cnt   <= strobe_load(RD_WAIT);
            r_state <= S_RD_STROBE;
          end
        end

        S_RD_STROBE: begin
          if (r_cnt == '0) begin
            r_rdata <= w_din;
            rd      <= 1'b0;
            en      <= 1'b0;
            addr    <= '0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        S_WR_STROBE: begin
          if (r_cnt == '0) begin
            wr      <= 1'b0;
            r_state <= S_WR_HOLD;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        S_WR_HOLD: begin
          // Data held one cycle past the falling wr before release.
          r_oe    <= 1'b0;
          en      <= 1'b0;
          addr    <= '0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end

        S_DONE: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_oe    <= 1'b0;
          r_ready <= 1'b1;
          en      <= 1'b0;
          rd      <= 1'b0;
          wr      <= 1'b0;
          addr    <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: directed bench for mem_bus_master with two instances
// (A: RD_WAIT=1/WR_WIDTH=1, B: RD_WAIT=3/WR_WIDTH=2), each on its own
// bus with a behavioural RAM responder.
module tb_mem_bus_master;
  import mem_bus_pkg::*;

  localparam int RDW_A = 1;
  localparam int WRW_A = 1;
  localparam int RDW_B = 3;
  localparam int WRW_B = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_bus_if ifa ();
  mem_bus_if ifb ();

  logic        a_en, a_rd, a_wr;
  logic [12:0] a_addr;
  wire  [7:0]  a_data;
  logic        b_en, b_rd, b_wr;
  logic [12:0] b_addr;
  wire  [7:0]  b_data;

  logic [7:0] a_mem [0:8191];
  logic [7:0] b_mem [0:8191];

  // Passive RAM responders: drive on read strobe, store on rising wr.
  assign a_data = (a_en && a_rd) ? a_mem[a_addr] : 8'hzz;
  assign b_data = (b_en && b_rd) ? b_mem[b_addr] : 8'hzz;
  always @(posedge a_wr) a_mem[a_addr] <= a_data;
  always @(posedge b_wr) b_mem[b_addr] <= b_data;

  mem_bus_master #(.RD_WAIT(RDW_A), .WR_WIDTH(WRW_A), .RAM_BASE(5'h00)) u_dut_a (
    .clk(clk), .rst(rst), .core(ifa),
    .en(a_en), .rd(a_rd), .wr(a_wr), .addr(a_addr), .data(a_data)
  );

  mem_bus_master #(.RD_WAIT(RDW_B), .WR_WIDTH(WRW_B), .RAM_BASE(5'h00)) u_dut_b (
    .clk(clk), .rst(rst), .core(ifb),
    .en(b_en), .rd(b_rd), .wr(b_wr), .addr(b_addr), .data(b_data)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] cur_wd [2];
  int         rd_run [2];
  int         wr_run [2];
  int         acc_cnt [2];
  int         done_cnt [2];
  logic       en_prev [2];

  logic        hw [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [12:0] ha [4] = '{13'h0100, 13'h0100, 13'h0101, 13'h0101};
  logic [7:0]  hd [4] = '{8'h11, 8'h11, 8'h22, 8'h22};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {oe, en, rd, wr, ready, done, err}
  function automatic logic [6:0] ctl(input int sel);
    if (sel == 0) return {u_dut_a.w_oe, a_en, a_rd, a_wr, ifa.ready, ifa.done, ifa.err};
    return {u_dut_b.w_oe, b_en, b_rd, b_wr, ifb.ready, ifb.done, ifb.err};
  endfunction

  function automatic logic [12:0] baddr(input int sel);
    return (sel == 0) ? a_addr : b_addr;
  endfunction

  function automatic logic [7:0] bdata(input int sel);
    return (sel == 0) ? a_data : b_data;
  endfunction

  function automatic logic [7:0] rdat(input int sel);
    return (sel == 0) ? ifa.rdata : ifb.rdata;
  endfunction

  task automatic set_req(input int sel, input logic r, input logic we,
                         input logic [12:0] a, input logic [7:0] wd);
    cur_wd[sel] = wd;
    if (sel == 0) begin
      ifa.req = r; ifa.we = we; ifa.req_addr = a; ifa.wdata = wd;
    end else begin
      ifb.req = r; ifb.we = we; ifb.req_addr = a; ifb.wdata = wd;
    end
  endtask

  // Per-cycle bus monitor for both instances.
  task automatic cycle_mon();
    logic [6:0] c;
    for (int s = 0; s < 2; s++) begin
      c = ctl(s);
      if (rst) begin
        rd_run[s]  = 0;
        wr_run[s]  = 0;
        en_prev[s] = 1'b0;
      end else begin
        if (c[4]) check("no_drive_during_rd", 32'(c[6]), 32'd0);
        if (c[6]) check("wdata_stable", 32'(bdata(s)), 32'(cur_wd[s]));
`ifndef MEM_BUS_RANGE_CHECK_EN
        if (c[1]) check("err_tied_low", 32'(c[0]), 32'd0);
`endif
        if (c[4]) rd_run[s]++;
        else if (rd_run[s] != 0) begin
          check("rd_width", 32'(rd_run[s]), 32'((s == 0) ? RDW_A : RDW_B));
          rd_run[s] = 0;
        end
        if (c[3]) wr_run[s]++;
        else if (wr_run[s] != 0) begin
          check("wr_width", 32'(wr_run[s]), 32'((s == 0) ? WRW_A : WRW_B));
          wr_run[s] = 0;
        end
        if (c[5] && !en_prev[s]) acc_cnt[s]++;
        en_prev[s] = c[5];
        if (c[1]) done_cnt[s]++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cycle_mon();
  endtask

  // One request/response transaction with latency and bus-state checks.
  task automatic op(input int sel, input logic we, input logic [12:0] a,
                    input logic [7:0] wd, input logic [7:0] exp_rd);
    logic [6:0] c;
    int lat;
    int exp_lat;
    if (we) exp_lat = 2 + ((sel == 0) ? WRW_A : WRW_B);
    else    exp_lat = 1 + ((sel == 0) ? RDW_A : RDW_B);
    c = ctl(sel);
    check("pre_ready", 32'(c[2]), 32'd1);
    set_req(sel, 1'b1, we, a, wd);
    tick();
    set_req(sel, 1'b0, we, a, wd);
    check("accept_ctl", 32'(ctl(sel)), 32'({we, 6'b100000}));
    check("accept_addr", 32'(baddr(sel)), 32'(a));
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      tick();
      c = ctl(sel);
      if (c[1]) lat = k;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("done_ctl", 32'(c), 32'(7'b0000010));
    check("done_addr", 32'(baddr(sel)), 32'd0);
    if (!we) check("rdata", 32'(rdat(sel)), 32'(exp_rd));
    tick();
    check("idle_ctl", 32'(ctl(sel)), 32'(7'b0000100));
    if (!we) check("rdata_hold", 32'(rdat(sel)), 32'(exp_rd));
  endtask

  initial begin
    logic [6:0] c;
    int lat;
    int a0, d0;

    for (int s = 0; s < 2; s++) begin
      cur_wd[s] = 8'h00; rd_run[s] = 0; wr_run[s] = 0;
      acc_cnt[s] = 0; done_cnt[s] = 0; en_prev[s] = 1'b0;
    end
    for (int i = 0; i < 8192; i++) begin
      a_mem[i] = 8'h00;
      b_mem[i] = 8'h00;
    end

    // Reset, with a request presented that must be ignored.
    rst = 1'b1;
    set_req(0, 1'b1, 1'b0, 13'h0042, 8'h00);
    set_req(1, 1'b1, 1'b1, 13'h0042, 8'hFF);
    tick();
    tick();
    check("reset_ctl_a", 32'(ctl(0)), 32'(7'b0000100));
    check("reset_ctl_b", 32'(ctl(1)), 32'(7'b0000100));
    check("reset_addr_a", 32'(baddr(0)), 32'd0);
    check("reset_rdata_a", 32'(rdat(0)), 32'd0);
    check("reset_rdata_b", 32'(rdat(1)), 32'd0);
    set_req(0, 1'b0, 1'b0, 13'h0000, 8'h00);
    set_req(1, 1'b0, 1'b0, 13'h0000, 8'h00);
    rst = 1'b0;
    tick();
    check("post_reset_idle_a", 32'(ctl(0)), 32'(7'b0000100));

    // Instance A: write then read back at minimum strobe widths.
    op(0, 1'b1, 13'h0042, 8'h3C, 8'h00);
    op(0, 1'b0, 13'h0042, 8'h00, 8'h3C);

    // Instance B: wider strobes, two writes and two reads.
    op(1, 1'b1, 13'h0010, 8'hA5, 8'h00);
    op(1, 1'b1, 13'h0011, 8'h5A, 8'h00);
    op(1, 1'b0, 13'h0010, 8'h00, 8'hA5);
    op(1, 1'b0, 13'h0011, 8'h00, 8'h5A);

    // Instance A: req held high across four alternating operations.
    a0 = acc_cnt[0];
    d0 = done_cnt[0];
    for (int i = 0; i < 4; i++) begin
      c = ctl(0);
      check("held_ready", 32'(c[2]), 32'd1);
      set_req(0, 1'b1, hw[i], ha[i], hw[i] ? hd[i] : 8'h00);
      tick();
      lat = 0;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
        tick();
        c = ctl(0);
        if (c[1]) lat = k;
      end
      check("held_latency", 32'(lat), hw[i] ? 32'd3 : 32'd2);
      if (!hw[i]) check("held_rdata", 32'(rdat(0)), 32'(hd[i]));
      tick();
    end
    set_req(0, 1'b0, 1'b0, 13'h0000, 8'h00);
    tick();
    check("held_accepts", 32'(acc_cnt[0] - a0), 32'd4);
    check("held_dones", 32'(done_cnt[0] - d0), 32'd4);

    // Instance B: reset in the middle of WR_STROBE.
    set_req(1, 1'b1, 1'b1, 13'h0020, 8'h77);
    tick();
    set_req(1, 1'b0, 1'b1, 13'h0020, 8'h77);
    tick();
    c = ctl(1);
    check("rst_mid_wr_active", 32'(c[3]), 32'd1);
    d0 = done_cnt[1];
    rst = 1'b1;
    tick();
    check("rst_mid_ctl", 32'(ctl(1)), 32'(7'b0000100));
    check("rst_mid_addr", 32'(baddr(1)), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("rst_mid_no_done", 32'(done_cnt[1] - d0), 32'd0);
    op(1, 1'b0, 13'h0020, 8'h00, 8'h77);

`ifdef MEM_BUS_RANGE_CHECK_EN
    // Out-of-window request rejected; in-window request served.
    a0 = acc_cnt[0];
    d0 = done_cnt[0];
    set_req(0, 1'b1, 1'b0, 13'h1F00, 8'h00);
    tick();
    set_req(0, 1'b0, 1'b0, 13'h0000, 8'h00);
    check("range_err_ctl", 32'(ctl(0)), 32'(7'b0000001));
    tick();
    check("range_err_clear", 32'(ctl(0)), 32'(7'b0000100));
    tick();
    check("range_no_bus", 32'(acc_cnt[0] - a0), 32'd0);
    check("range_no_done", 32'(done_cnt[0] - d0), 32'd0);
    op(0, 1'b1, 13'h00FF, 8'hC3, 8'h00);
    op(0, 1'b0, 13'h00FF, 8'h00, 8'hC3);
`else
    // Without the range check, high addresses go straight to the bus.
    op(0, 1'b1, 13'h1F00, 8'h99, 8'h00);
    op(0, 1'b0, 13'h1F00, 8'h00, 8'h99);
    op(0, 1'b0, 13'h00FF, 8'h00, 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
